// File: rtl/round_out_writeback.sv
// round_out_writeback: output writeback stage behind the 32-lane rounding stage.
// Accepts 256b lines (32 x signed 8b) over valid/ready, applies optional per-lane ReLU,
// buffers lines in a DEPTH-entry FIFO and issues one SRAM write per line from an
// auto-incrementing line address. A job is a start pulse, LEN lines, then a done pulse.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_start               job start pulse, only honoured in IDLE
//   i_base_addr/i_len     first write address / line count, latched on accepted start
//   i_relu_en             ReLU enable, latched on accepted start
//   i_dat_vld/i_dat       upstream line (lane k = bits [8k+7:8k])
//   o_dat_rdy             upstream ready
//   o_wr_en/o_wr_addr     SRAM write request / line address
//   o_wr_dat, i_wr_rdy    SRAM write data / SRAM accepts this cycle
//   o_busy, o_done        busy in RUN and DRAIN / one-cycle completion pulse
module round_out_writeback #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_relu_en,
  input  logic              i_dat_vld,
  input  logic [255:0]      i_dat,
  output logic              o_dat_rdy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [255:0]      o_wr_dat,
  input  logic              i_wr_rdy,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  in_cnt_q;
  logic              relu_q;
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [PtrW:0]     cnt_q;
  logic [255:0]      mem_q [DEPTH];

  logic              fifo_full, fifo_empty;
  logic              dat_rdy, wr_en;
  logic              push, pop, start_ok;
  logic [255:0]      relu_dat;

  assign fifo_full  = (cnt_q == FullCnt);
  assign fifo_empty = (cnt_q == '0);
  assign start_ok   = (state_q == StIdle) && i_start;
  assign push       = i_dat_vld && dat_rdy;
  assign pop        = wr_en && i_wr_rdy;

  // ReLU clamps negative lanes (sign bit set) to zero.
  always_comb begin
    relu_dat = i_dat;
    for (int k = 0; k < 32; k++) begin
      if (relu_q && i_dat[8*k+7]) begin
        relu_dat[8*k +: 8] = 8'h00;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = (i_len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (push && ((in_cnt_q + LEN_W'(1)) == len_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as soon as the last write is accepted so done follows it by one cycle.
        if (fifo_empty || ((cnt_q == (PtrW + 1)'(1)) && pop)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy    = (state_q == StRun) || (state_q == StDrain);
    o_done    = (state_q == StDone);
    dat_rdy   = (state_q == StRun) && !fifo_full && (in_cnt_q < len_q);
    wr_en     = o_busy && !fifo_empty;
    o_dat_rdy = dat_rdy;
    o_wr_en   = wr_en;
    o_wr_addr = addr_q;
    // Head is gated so the data bus reads zero whenever no write is requested.
    o_wr_dat  = wr_en ? mem_q[rptr_q] : '0;
  end

  // Job configuration, address and input counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      relu_q   <= 1'b0;
      in_cnt_q <= '0;
    end else if (start_ok) begin
      addr_q   <= i_base_addr;
      len_q    <= i_len;
      relu_q   <= i_relu_en;
      in_cnt_q <= '0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (push) begin
        in_cnt_q <= in_cnt_q + LEN_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the entry is not occupied.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wptr_q] <= relu_dat;
    end
  end

endmodule

// File: tb/tb_round_out_writeback.sv
module tb_round_out_writeback;

  localparam int Depth = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [11:0]  i_base_addr;
  logic [11:0]  i_len;
  logic         i_relu_en;
  logic         i_dat_vld;
  logic [255:0] i_dat;
  logic         o_dat_rdy;
  logic         o_wr_en;
  logic [11:0]  o_wr_addr;
  logic [255:0] o_wr_dat;
  logic         i_wr_rdy;
  logic         o_busy;
  logic         o_done;

  int tests = 0;
  int fails = 0;

  logic [255:0] lines [64];

  round_out_writeback #(
    .DEPTH (4),
    .ADDR_W(12),
    .LEN_W (12)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_len      (i_len),
    .i_relu_en  (i_relu_en),
    .i_dat_vld  (i_dat_vld),
    .i_dat      (i_dat),
    .o_dat_rdy  (o_dat_rdy),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_dat   (o_wr_dat),
    .i_wr_rdy   (i_wr_rdy),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Reference ReLU: negative signed lanes become zero.
  function automatic logic [255:0] relu_ref(input logic [255:0] d, input bit en);
    logic [255:0] r = d;
    for (int k = 0; k < 32; k++) begin
      if (en && ($signed(d[8*k +: 8]) < 0)) r[8*k +: 8] = 8'h00;
    end
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  o_dat_rdy, 0);
    chk({tag, "_wren"}, o_wr_en,   0);
    chk({tag, "_addr"}, o_wr_addr, 0);
    chk({tag, "_dat"},  o_wr_dat,  0);
    chk({tag, "_busy"}, o_busy,    0);
    chk({tag, "_done"}, o_done,    0);
  endtask

  // Runs one job against a scoreboard: accepted-line count and written-line count
  // determine every expected output (occupancy = acc - wr).
  task automatic run_job(input logic [11:0] base, input logic [11:0] len, input bit relu,
                         input int vld_pct, input int rdy_pct, input int stall,
                         input bit restart);
    int acc = 0;
    int wr = 0;
    int cyc = 0;
    bit exp_done = 0;
    bit done_seen = 0;
    bit exp_rdy, exp_wr;
    for (int i = 0; i < len; i++) lines[i] = rand256();
    @(negedge i_clk);
    i_start = 1; i_base_addr = base; i_len = len; i_relu_en = relu;
    i_dat_vld = 0; i_wr_rdy = 0;
    #1 chk("idle_busy", o_busy, 0);
    @(negedge i_clk);
    i_base_addr = 12'($urandom); i_len = 12'($urandom); i_relu_en = 1'($urandom);
    while (!done_seen && cyc < 2000) begin
      i_start = restart && (cyc == 2);
      if (i_start) i_len = 12'd1;
      i_dat_vld = ($urandom_range(99) < vld_pct);
      i_dat = (i_dat_vld && acc < len) ? lines[acc] : rand256();
      i_wr_rdy = (cyc >= stall) && ($urandom_range(99) < rdy_pct);
      #1;
      if (stall > 0 && cyc == stall && vld_pct == 100)
        chk("full_accept_cnt", acc, (len < Depth) ? len : Depth);
      if (exp_done) begin
        chk("done_pulse", o_done, 1);
        chk("done_busy", o_busy, 0);
        chk("done_wren", o_wr_en, 0);
        chk("done_rdy", o_dat_rdy, 0);
        done_seen = 1;
      end else begin
        exp_rdy = (acc < len) && (acc - wr < Depth);
        exp_wr  = (acc > wr);
        chk("run_done", o_done, 0);
        chk("run_busy", o_busy, 1);
        chk("run_rdy", o_dat_rdy, exp_rdy);
        chk("run_wren", o_wr_en, exp_wr);
        if (exp_wr) begin
          chk("wr_addr", o_wr_addr, 12'(base + wr));
          chk("wr_dat", o_wr_dat, relu_ref(lines[wr], relu));
        end
        if (i_dat_vld && exp_rdy) acc++;
        if (exp_wr && i_wr_rdy) begin
          wr++;
          if (wr == len) exp_done = 1;
        end
        @(negedge i_clk);
        cyc++;
      end
    end
    if (!done_seen) chk("job_timeout", 0, 1);
    i_start = 0; i_dat_vld = 0;
    @(negedge i_clk);
    #1;
    chk("post_done", o_done, 0);
    chk("post_busy", o_busy, 0);
  endtask

  typedef struct {
    logic [11:0]  base;
    bit           relu;
    logic [255:0] dat;
    logic [11:0]  exp_addr;
    logic [255:0] exp_dat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{12'h010, 0, {224'h0, 32'h00FF7F80}, 12'h010, {224'h0, 32'h00FF7F80}};
    vecs[1] = '{12'h020, 1, {224'h0, 32'h00FF7F80}, 12'h020, {224'h0, 32'h00007F00}};
    vecs[2] = '{12'hFFF, 1, {32{8'h81}}, 12'hFFF, 256'h0};
    vecs[3] = '{12'h123, 1, {16{16'h7F80}}, 12'h123, {16{16'h7F00}}};
    vecs[4] = '{12'h456, 0, {16{16'h7F80}}, 12'h456, {16{16'h7F80}}};

    i_rst_n = 0; i_start = 0; i_base_addr = 0; i_len = 0; i_relu_en = 0;
    i_dat_vld = 0; i_dat = 0; i_wr_rdy = 0;
    #3 chk_all_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1;
    #1 chk_all_zero("after_reset");

    // Single-line jobs from the vector table
    for (int v = 0; v < 5; v++) begin
      @(negedge i_clk);
      i_start = 1; i_base_addr = vecs[v].base; i_len = 1; i_relu_en = vecs[v].relu;
      i_wr_rdy = 1; i_dat_vld = 0;
      @(negedge i_clk);
      i_start = 0; i_dat_vld = 1; i_dat = vecs[v].dat;
      #1 chk("vec_rdy", o_dat_rdy, 1);
      chk("vec_wren_early", o_wr_en, 0);
      @(negedge i_clk);
      i_dat_vld = 0;
      #1 chk("vec_wren", o_wr_en, 1);
      chk("vec_addr", o_wr_addr, vecs[v].exp_addr);
      chk("vec_dat", o_wr_dat, vecs[v].exp_dat);
      @(negedge i_clk);
      #1 chk("vec_done", o_done, 1);
      chk("vec_done_wren", o_wr_en, 0);
      @(negedge i_clk);
      #1 chk("vec_idle_done", o_done, 0);
    end

    // Basic back-to-back job
    run_job(12'h010, 12'd3, 0, 100, 100, 0, 0);
    // Address wrap
    run_job(12'hFFE, 12'd4, 1, 100, 100, 0, 0);
    // Backpressure until full, continuous valid, overrun offers, ignored restart
    run_job(12'h300, 12'd6, 0, 100, 100, 10, 1);

    // Zero-length job
    @(negedge i_clk);
    i_start = 1; i_len = 0; i_base_addr = 12'h055; i_wr_rdy = 1;
    @(negedge i_clk);
    i_start = 0;
    #1 chk("len0_done", o_done, 1);
    chk("len0_wren", o_wr_en, 0);
    chk("len0_busy", o_busy, 0);
    @(negedge i_clk);
    #1 chk("len0_done_clr", o_done, 0);
    chk("len0_wren2", o_wr_en, 0);

    // Reset mid-job with two lines buffered
    @(negedge i_clk);
    i_start = 1; i_len = 5; i_base_addr = 12'h100; i_relu_en = 0; i_wr_rdy = 0;
    @(negedge i_clk);
    i_start = 0; i_dat_vld = 1; i_dat = rand256();
    @(negedge i_clk);
    i_dat = rand256();
    @(negedge i_clk);
    i_dat_vld = 0;
    #1 chk("mid_wren", o_wr_en, 1);
    chk("mid_busy", o_busy, 1);
    #1 i_rst_n = 0;
    #1 chk_all_zero("mid_reset");
    @(negedge i_clk);
    i_rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      #1 chk("post_rst_done", o_done, 0);
      chk("post_rst_wren", o_wr_en, 0);
    end
    run_job(12'h200, 12'd3, 1, 100, 100, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      run_job(12'($urandom), 12'($urandom_range(20, 1)), 1'($urandom),
              $urandom_range(100, 30), $urandom_range(100, 30),
              $urandom_range(6, 0), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
